// File: rtl/ahb_ram_store_ctrl.sv
// rtl/ahb_ram_store_ctrl.sv - AHB-Lite slave sequencing a word-wide RAM with sub-word read-modify-write
module ahb_ram_store_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int RAM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [31:0]       haddr,
    input  logic [31:0]       hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic              hresp,
    output logic [31:0]       hrdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_WORD, S_RD_REQ, S_RD_DATA, S_RMW_RD, S_RMW_WR, S_ERR1, S_ERR2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_size;
    logic [1:0]        r_lane;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_hrdata;
    logic              w_completing;
    logic              w_accept;
    logic              w_illegal;
    logic [31:0]       w_merged;

    assign w_completing = (r_state == S_IDLE)    || (r_state == S_WR_WORD) ||
                          (r_state == S_RD_DATA) || (r_state == S_RMW_WR)  ||
                          (r_state == S_ERR2);
    assign w_accept     = hsel && htrans[1] && hready && w_completing;
    assign w_illegal    = (hsize > 3'b010) ||
                          ((hsize == 3'b001) && haddr[0]) ||
                          ((hsize == 3'b010) && (haddr[1:0] != 2'b00));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_size   <= 3'b000;
            r_lane   <= 2'b00;
            r_addr   <= '0;
            r_wdata  <= 32'h0;
            r_hrdata <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_size <= hsize;
                r_lane <= haddr[1:0];
                r_addr <= haddr[ADDR_W+1:2];
            end
            if (r_state == S_RMW_RD) begin
                r_wdata <= hwdata;
            end
            if (r_state == S_RD_DATA) begin
                r_hrdata <= ram_rdata;
            end
        end
    end

    // Little-endian lane merge of the captured store data into the word read back in RMW_RD.
    always_comb begin
        w_merged = ram_rdata;
        if (r_size == 3'b000) begin
            w_merged[{r_lane, 3'b000} +: 8] = r_wdata[{r_lane, 3'b000} +: 8];
        end else if (r_lane[1]) begin
            w_merged[31:16] = r_wdata[31:16];
        end else begin
            w_merged[15:0] = r_wdata[15:0];
        end
    end

    always_comb begin
        w_next    = r_state;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = r_hrdata;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = 32'h0;
        case (r_state)
            S_WR_WORD: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = r_addr;
                ram_wdata = hwdata;
            end
            S_RD_REQ: begin
                ram_en    = 1'b1;
                ram_addr  = r_addr;
                hreadyout = 1'b0;
                w_next    = S_RD_DATA;
            end
            S_RD_DATA: begin
                hrdata = ram_rdata;
            end
            S_RMW_RD: begin
                ram_en    = 1'b1;
                ram_addr  = r_addr;
                hreadyout = 1'b0;
                w_next    = S_RMW_WR;
            end
            S_RMW_WR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = r_addr;
                ram_wdata = w_merged;
            end
            S_ERR1: begin
                hresp     = 1'b1;
                hreadyout = 1'b0;
                w_next    = S_ERR2;
            end
            S_ERR2: begin
                hresp = 1'b1;
            end
            default: begin
            end
        endcase
        if (w_completing) begin
            if (!w_accept) begin
                w_next = S_IDLE;
            end else if (w_illegal) begin
                w_next = S_ERR1;
            end else if (!hwrite) begin
                w_next = S_RD_REQ;
            end else if (hsize == 3'b010) begin
                w_next = S_WR_WORD;
            end else begin
                w_next = S_RMW_RD;
            end
        end
    end

endmodule

// File: doc/ahb_ram_store_ctrl.md
Name: ahb_ram_store_ctrl

Overview:
AHB-Lite slave controller in front of the single-port, word-wide data RAM, which has no byte enables. It sequences all accesses to that RAM, including the read-modify-write needed for SB/SH stores. It also inserts wait states and returns the two-cycle ERROR response for illegal transfers. It sits between the core's AHB bus interface and the data RAM macro.

Parameters:
ADDR_W, 10, RAM word-address width; RAM depth = 2**ADDR_W words.
RAM_RD_LAT, 1, RAM read latency in cycles; fixed at 1 for this revision.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
hsel  in  1  slave select
htrans  in  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
hwrite  in  1  1 = write
hsize  in  3  000 byte, 001 half, 010 word, others illegal
haddr  in  32  byte address; bits [ADDR_W+1:2] select the RAM word
hwdata  in  32  write data, valid in the data phase
hready  in  1  bus-level HREADY; an address phase is accepted only when 1
hreadyout  out  1  slave ready
hresp  out  1  0 OKAY, 1 ERROR
hrdata  out  32  read data
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write, qualified by ram_en
ram_addr  out  ADDR_W  RAM word address
ram_wdata  out  32  RAM write word
ram_rdata  in  32  RAM read word, valid 1 cycle after ram_en & !ram_we

Behaviour:
- Reset values: hreadyout=1, hresp=0, hrdata=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, FSM=IDLE, all captured address-phase registers cleared.
- Accept condition: hsel & htrans[1] & hready. On accept, register hwrite, hsize, haddr[1:0] and the word address. Any other cycle (IDLE/BUSY/unselected) → next state IDLE, OKAY, zero wait, no RAM access.
- Legality check at accept: illegal if hsize>010, or hsize=001 with haddr[0]=1, or hsize=010 with haddr[1:0]≠00.
- FSM states: IDLE, WR_WORD, RD_REQ, RD_DATA, RMW_RD, RMW_WR, ERR1, ERR2.
- Accept transitions from IDLE or any completing state:
  - illegal → ERR1
  - write word → WR_WORD
  - write byte/half → RMW_RD
  - read → RD_REQ
- WR_WORD (data phase, 0 wait): ram_en=1, ram_we=1, ram_wdata=hwdata, hreadyout=1.
- RD_REQ: ram_en=1, ram_we=0, hreadyout=0 → RD_DATA.
- RD_DATA: hrdata=ram_rdata (full word, all lanes; the master selects the lane), hreadyout=1. Read = 1 wait state.
- RMW_RD: capture hwdata into a register, ram_en=1, ram_we=0, hreadyout=0 → RMW_WR.
- RMW_WR: ram_en=1, ram_we=1, hreadyout=1. ram_wdata = ram_rdata with the addressed lane replaced from the captured hwdata (little-endian):
  - byte: lane k=haddr[1:0], bits [8k+7:8k] taken from hwdata[8k+7:8k]
  - half: haddr[1]=0 → bits [15:0]; haddr[1]=1 → bits [31:16]
  - Sub-word store = 1 wait state.
- ERR1: hresp=1, hreadyout=0, no RAM access → ERR2. ERR2: hresp=1, hreadyout=1; the next accept is evaluated here as in any completing state.
- Pipelining:
  - A new address phase overlapping a completing data phase (WR_WORD, RD_DATA, RMW_WR, ERR2) is accepted in that cycle.
  - While hreadyout=0, no accept occurs, because hready=0.
- Hazards: a read accepted during RMW_WR issues its RAM read the next cycle, after the write commits, so it returns the merged word. No forwarding is needed.
- hrdata holds its last value outside RD_DATA.
- Reset in any state: return to IDLE next cycle; an RMW in progress is abandoned with no RAM write; no ERROR is issued.

Test Plan:
- Word write 0xDEADBEEF @0x10, then word read @0x10 → write 0 wait, ram_we in data phase with addr 4. Read: hreadyout low 1 cycle, hrdata=0xDEADBEEF.
- RAM[4]=0x11223344; SB hwdata=0x00AA0000 @0x12 → RMW_RD then RMW_WR, ram_wdata=0x11AA3344, 1 wait state; read back =0x11AA3344.
- RAM[4]=0x11223344; SH hwdata=0xBEEF0000 @0x12 → ram_wdata=0xBEEF3344. SH @0x10 with hwdata=0x0000CAFE → 0x1122CAFE.
- SH @0x11 and SW @0x12 → two-cycle ERROR (hresp 1/hreadyout 0, then hresp 1/hreadyout 1); RAM contents unchanged.
- Back-to-back SB @0x13 (data 0x77000000) then read @0x10 on the next cycle → read returns the merged word 0x77223344.
- Assert rst during RMW_RD of SB @0x10 → no ram_we ever asserted; outputs at reset values the following cycle.
